// File: rtl/rv32_hazard_pkg.sv
// Purpose: shared types and sizing helpers for the RV32 hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_hazard_pkg;

    typedef enum logic [1:0] {
        INIT             = 2'd0,
        RUN              = 2'd1,
        REDIRECT_PENDING = 2'd2
    } hz_state_t;

    localparam int RESET_FLUSH_CYCLES_DEFAULT = 4;

    // Width of the post-reset flush counter. Clamped to one bit so a zero
    // flush length still yields a legal vector.
    function automatic int flush_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    localparam int FLUSH_CNT_W = flush_cnt_width(RESET_FLUSH_CYCLES_DEFAULT);

endpackage

// File: rtl/rv32_perf_counter.sv
// Purpose: 32-bit free-running enable counter, wraps to 0 after all-ones.
// Latency: count_out reflects an enable one cycle after it is sampled.
// Backpressure: none; counts every enabled cycle.
//   clk, reset_n : clock, async active-low reset (clears count)
//   en_in        : increment this cycle
//   count_out    : current count
module rv32_perf_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_in,
    output logic [31:0] count_out
);

    logic [31:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 32'd0;
        end else if (en_in) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// Purpose: per-stage stall/flush and fetch-redirect control for the 5-stage RV32 pipe.
// Latency: stall/flush/redirect are combinational; state, latched PC and counters update on clk.
// Backpressure: data-bus wait freezes fetch..mem; instruction-bus wait stalls fetch only.
//   Inputs : decode sources, execute load/rd, memory-stage branch, instr/data bus handshakes.
//   Outputs: {fetch,decode,execute,mem}_{stall,flush}_out, redirect_valid/pc, stall/redirect counts.
module rv32_hazard_ctrl
    import rv32_hazard_pkg::*;
#(
    parameter int RESET_FLUSH_CYCLES = RESET_FLUSH_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  decode_rs1_in,
    input  logic [4:0]  decode_rs2_in,
    input  logic        decode_rs1_read_in,
    input  logic        decode_rs2_read_in,
    input  logic        execute_mem_read_en_in,
    input  logic [4:0]  execute_rd_in,
    input  logic        mem_branch_taken_in,
    input  logic [31:0] mem_branch_pc_in,
    input  logic        instr_read_in,
    input  logic        instr_ready_in,
    input  logic        data_access_in,
    input  logic        data_ready_in,
    output logic        fetch_stall_out,
    output logic        fetch_flush_out,
    output logic        decode_stall_out,
    output logic        decode_flush_out,
    output logic        execute_stall_out,
    output logic        execute_flush_out,
    output logic        mem_stall_out,
    output logic        mem_flush_out,
    output logic        redirect_valid_out,
    output logic [31:0] redirect_pc_out,
    output logic [31:0] stall_count_out,
    output logic [31:0] redirect_count_out
);

    localparam int CNT_W = flush_cnt_width(RESET_FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (RESET_FLUSH_CYCLES > 0) ? CNT_W'(RESET_FLUSH_CYCLES - 1) : '0;

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [31:0]      pend_pc_q, pend_pc_d;

    logic data_wait;
    logic bus_busy;
    logic load_use;
    logic any_stall;

    assign data_wait = data_access_in && !data_ready_in;
    assign bus_busy  = instr_read_in && !instr_ready_in;
    // x0 never carries a dependency, so a load targeting it is never a hazard.
    assign load_use  = execute_mem_read_en_in && (execute_rd_in != 5'd0) &&
                       ((decode_rs1_read_in && (decode_rs1_in == execute_rd_in)) ||
                        (decode_rs2_read_in && (decode_rs2_in == execute_rd_in)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            pend_pc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        init_cnt_d         = init_cnt_q;
        pend_pc_d          = pend_pc_q;
        fetch_stall_out    = 1'b0;
        fetch_flush_out    = 1'b0;
        decode_stall_out   = 1'b0;
        decode_flush_out   = 1'b0;
        execute_stall_out  = 1'b0;
        execute_flush_out  = 1'b0;
        mem_stall_out      = 1'b0;
        mem_flush_out      = 1'b0;
        redirect_valid_out = 1'b0;
        redirect_pc_out    = 32'd0;

        case (state_q)
            INIT: begin
                fetch_flush_out   = 1'b1;
                decode_flush_out  = 1'b1;
                execute_flush_out = 1'b1;
                mem_flush_out     = 1'b1;
                if (init_cnt_q >= CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: begin
                if (data_wait) begin
                    // Whole pipe frozen; state holds so a pending redirect
                    // survives, and the frozen mem stage re-presents its branch.
                    fetch_stall_out   = 1'b1;
                    decode_stall_out  = 1'b1;
                    execute_stall_out = 1'b1;
                    mem_stall_out     = 1'b1;
                end else if (state_q == RUN && mem_branch_taken_in) begin
                    decode_flush_out  = 1'b1;
                    execute_flush_out = 1'b1;
                    if (bus_busy) begin
                        // Cannot redirect mid-read: remember the target and
                        // hold fetch until the wrong-path word lands.
                        fetch_stall_out = 1'b1;
                        pend_pc_d       = mem_branch_pc_in;
                        state_d         = REDIRECT_PENDING;
                    end else begin
                        fetch_flush_out    = 1'b1;
                        redirect_valid_out = 1'b1;
                        redirect_pc_out    = mem_branch_pc_in;
                    end
                end else if (state_q == REDIRECT_PENDING) begin
                    // A second branch should never arrive here; if one does,
                    // the newest target wins.
                    if (mem_branch_taken_in) begin
                        pend_pc_d = mem_branch_pc_in;
                    end
                    if (!instr_ready_in) begin
                        fetch_stall_out  = 1'b1;
                        decode_flush_out = 1'b1;
                    end else begin
                        fetch_flush_out    = 1'b1;
                        redirect_valid_out = 1'b1;
                        redirect_pc_out    = mem_branch_taken_in ? mem_branch_pc_in : pend_pc_q;
                        state_d            = RUN;
                    end
                end else if (load_use) begin
                    fetch_stall_out   = 1'b1;
                    decode_stall_out  = 1'b1;
                    execute_flush_out = 1'b1;
                end else if (bus_busy) begin
                    fetch_stall_out  = 1'b1;
                    decode_flush_out = 1'b1;
                end
            end
        endcase
    end

    assign any_stall = (state_q != INIT) &&
                       (fetch_stall_out || decode_stall_out || execute_stall_out || mem_stall_out);

    rv32_perf_counter u_stall_count (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_in     (any_stall),
        .count_out (stall_count_out)
    );

    rv32_perf_counter u_redirect_count (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_in     (redirect_valid_out),
        .count_out (redirect_count_out)
    );

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Purpose: self-checking bench for rv32_hazard_ctrl (directed cases plus random traffic).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_rv32_hazard_ctrl;

    localparam int RF = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_rd, rs2_rd, ld;
    logic        br;
    logic [31:0] br_pc;
    logic        ir, irdy, da, drdy;

    logic        fs, ff, ds, df, es, ef, ms, mf, rv;
    logic [31:0] rpc, scnt, rcnt;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b1;

    always #5 clk = ~clk;

    rv32_hazard_ctrl #(.RESET_FLUSH_CYCLES(RF)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .decode_rs1_in          (rs1),
        .decode_rs2_in          (rs2),
        .decode_rs1_read_in     (rs1_rd),
        .decode_rs2_read_in     (rs2_rd),
        .execute_mem_read_en_in (ld),
        .execute_rd_in          (rd),
        .mem_branch_taken_in    (br),
        .mem_branch_pc_in       (br_pc),
        .instr_read_in          (ir),
        .instr_ready_in         (irdy),
        .data_access_in         (da),
        .data_ready_in          (drdy),
        .fetch_stall_out        (fs),
        .fetch_flush_out        (ff),
        .decode_stall_out       (ds),
        .decode_flush_out       (df),
        .execute_stall_out      (es),
        .execute_flush_out      (ef),
        .mem_stall_out          (ms),
        .mem_flush_out          (mf),
        .redirect_valid_out     (rv),
        .redirect_pc_out        (rpc),
        .stall_count_out        (scnt),
        .redirect_count_out     (rcnt)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        fs, ff, ds, df, es, ef, ms, mf, rv;
        logic [31:0] pc;
    } exp_t;

    int          m_init_left;   // flush cycles still owed after reset
    bit          m_pending;     // a redirect is waiting for the instruction bus
    logic [31:0] m_pc;
    logic [31:0] m_scnt, m_rcnt;

    function automatic exp_t model_out();
        exp_t e;
        bit busy, lu;
        e = '0;
        if (!reset_n || m_init_left > 0) begin
            e.ff = 1; e.df = 1; e.ef = 1; e.mf = 1;
            return e;
        end
        busy = ir && !irdy;
        lu = ld && (rd != 0) && ((rs1_rd && rs1 == rd) || (rs2_rd && rs2 == rd));
        if (da && !drdy) begin
            e.fs = 1; e.ds = 1; e.es = 1; e.ms = 1;
        end else if (!m_pending && br) begin
            e.df = 1; e.ef = 1;
            if (busy) e.fs = 1;
            else begin e.ff = 1; e.rv = 1; e.pc = br_pc; end
        end else if (m_pending) begin
            if (!irdy) begin e.fs = 1; e.df = 1; end
            else begin e.ff = 1; e.rv = 1; e.pc = br ? br_pc : m_pc; end
        end else if (lu) begin
            e.fs = 1; e.ds = 1; e.ef = 1;
        end else if (busy) begin
            e.fs = 1; e.df = 1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        exp_t e;
        if (!reset_n) begin
            m_init_left = RF;
            m_pending   = 0;
            m_pc        = 0;
            m_scnt      = 0;
            m_rcnt      = 0;
        end else if (m_init_left > 0) begin
            m_init_left = m_init_left - 1;
        end else begin
            e = model_out();
            if (e.fs || e.ds || e.es || e.ms) m_scnt = m_scnt + 32'd1;
            if (e.rv) m_rcnt = m_rcnt + 32'd1;
            if (!(da && !drdy)) begin
                if (!m_pending && br && ir && !irdy) begin
                    m_pending = 1; m_pc = br_pc;
                end else if (m_pending) begin
                    if (br) m_pc = br_pc;
                    if (irdy) m_pending = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e, g;
        if (check_en) begin
            e = model_out();
            g = '{fs, ff, ds, df, es, ef, ms, mf, rv, rpc};
            if (!e.rv) g.pc = '0;
            if (!e.rv) e.pc = '0;
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL ctrl_outputs t=%0t: got %h want %h", $time, g, e);
            end
            n_checks++;
            if ({scnt, rcnt} !== {m_scnt, m_rcnt}) begin
                n_errors++;
                $display("FAIL counters t=%0t: got stall=%h redir=%h want stall=%h redir=%h",
                         $time, scnt, rcnt, m_scnt, m_rcnt);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs1 = 0; rs2 = 0; rd = 0; rs1_rd = 0; rs2_rd = 0; ld = 0;
        br = 0; br_pc = 0; ir = 0; irdy = 0; da = 0; drdy = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_in();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_flush", {28'd0, ff, df, ef, mf}, 32'hF);
        chk("reset_stall", {28'd0, fs, ds, es, ms}, 32'h0);
        chk("reset_redirect", {31'd0, rv}, 32'h0);
        tick();
        reset_n = 1'b1;

        // exactly RF flush cycles after release
        for (int i = 0; i < RF + 2; i++) begin
            @(negedge clk);
            chk($sformatf("init_flush_%0d", i), {31'd0, mf}, (i < RF) ? 32'd1 : 32'd0);
        end
        chk("init_counts", scnt | rcnt, 32'd0);

        // load-use: rd=5, rs2=5 read
        tick();
        ld = 1; rd = 5; rs2 = 5; rs2_rd = 1; rs1 = 3; rs1_rd = 1;
        @(negedge clk);
        chk("lu_stall", {29'd0, fs, ds, ef}, 32'h7);
        tick();
        clear_in();
        @(negedge clk);
        chk("lu_one_bubble", {31'd0, fs}, 32'd0);
        chk("lu_stall_count", scnt, 32'd1);
        tick();
        ld = 1; rd = 0; rs2 = 0; rs2_rd = 1;
        @(negedge clk);
        chk("lu_x0_nostall", {29'd0, fs, ds, ef}, 32'h0);
        tick();
        clear_in();

        // taken branch, bus idle
        br = 1; br_pc = 32'h0000_0100;
        @(negedge clk);
        chk("br_idle_valid", {31'd0, rv}, 32'd1);
        chk("br_idle_pc", rpc, 32'h100);
        chk("br_idle_flush", {28'd0, ff, df, ef, mf}, 32'hE);
        tick();
        clear_in();
        @(negedge clk);
        chk("br_idle_rcount", rcnt, 32'd1);

        // branch during instruction wait: ready low 3 cycles
        tick();
        ir = 1; irdy = 0; br = 1; br_pc = 32'h0000_0200;
        @(negedge clk);
        chk("brw_c1", {26'd0, fs, ff, df, ef, rv, ds}, {26'd0, 6'b101100});
        tick();
        br = 0; br_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("brw_pending_%0d", i), {28'd0, fs, df, rv, ff}, 32'b1100);
            tick();
        end
        irdy = 1;
        @(negedge clk);
        chk("brw_ready_flush", {30'd0, ff, fs}, 32'b10);
        chk("brw_ready_pc", rv ? rpc : 32'hFFFF_FFFF, 32'h200);
        tick();
        clear_in();
        @(negedge clk);
        chk("brw_rcount", rcnt, 32'd2);
        chk("brw_scount", scnt, 32'd4);

        // data wait with concurrent branch
        tick();
        da = 1; drdy = 0; br = 1; br_pc = 32'h300;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("dw_stall_%0d", i), {27'd0, fs, ds, es, ms, rv}, 32'b11110);
            tick();
        end
        drdy = 1;
        @(negedge clk);
        chk("dw_scount", scnt, 32'd6);
        chk("dw_replay_pc", rv ? rpc : 32'hFFFF_FFFF, 32'h300);
        tick();
        clear_in();

        // stall counter wrap
        check_en = 1'b0;
        force dut.u_stall_count.count_q = 32'hFFFF_FFFF;
        m_scnt = 32'hFFFF_FFFF;
        #1 release dut.u_stall_count.count_q;
        ir = 1; irdy = 0;
        @(negedge clk);
        chk("wrap_pre", scnt, 32'hFFFF_FFFF);
        #1 check_en = 1'b1;
        tick();
        clear_in();
        @(negedge clk);
        chk("wrap_post", scnt, 32'd0);

        // reset during a pending redirect drops it
        tick();
        ir = 1; irdy = 0; br = 1; br_pc = 32'h400;
        tick();
        br = 0;
        @(negedge clk);
        chk("rst_pend_setup", {31'd0, fs}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk("rst_async_out", {27'd0, ff, mf, fs, ds, rv}, 32'b11000);
        tick();
        reset_n = 1'b1;
        repeat (RF) tick();
        irdy = 1;
        @(negedge clk);
        chk("rst_drop_redirect", {30'd0, rv, ff}, 32'd0);
        chk("rst_rcount", rcnt, 32'd0);
        tick();
        clear_in();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            rs1    = 5'($urandom_range(0, 7));
            rs2    = 5'($urandom_range(0, 7));
            rd     = 5'($urandom_range(0, 7));
            rs1_rd = ($urandom_range(0, 3) != 0);
            rs2_rd = ($urandom_range(0, 1) != 0);
            ld     = ($urandom_range(0, 9) < 3);
            br     = ($urandom_range(0, 19) < 3);
            br_pc  = $urandom;
            ir     = ($urandom_range(0, 9) < 7);
            irdy   = ($urandom_range(0, 1) != 0);
            da     = ($urandom_range(0, 9) < 2);
            drdy   = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
        end
        tick();
        clear_in();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_hazard_ctrl.md
# rv32_hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32 core: fetch, decode, execute, memory, writeback. It generates the per-stage stall and flush strobes consumed by the stage registers, and redirects fetch on taken branches, including when a branch resolves while an instruction-bus read is outstanding. It also flushes the reset-less pipeline registers after reset and keeps two wrap-around performance counters. Operand forwarding stays inside execute. This block only removes hazards that forwarding cannot cover.

## Interface
- RESET_FLUSH_CYCLES, 4: cycles after reset release during which every stage is flushed.
- clk  in  1  clock, all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- decode_rs1_in / decode_rs2_in  in  5  source registers of the instruction in decode.
- decode_rs1_read_in / decode_rs2_read_in  in  1  the instruction in decode actually reads that source.
- execute_mem_read_en_in  in  1  the instruction entering execute (decode output register) is a load.
- execute_rd_in  in  5  destination of that instruction.
- mem_branch_taken_in  in  1  branch resolved taken in the memory stage.
- mem_branch_pc_in  in  32  branch target.
- instr_read_in / instr_ready_in  in  1  instruction-bus request / completion.
- data_access_in / data_ready_in  in  1  memory stage has a load or store / data-bus completion.
- fetch_stall_out, fetch_flush_out, decode_stall_out, decode_flush_out, execute_stall_out, execute_flush_out, mem_stall_out, mem_flush_out  out  1 each  stage register controls; flush is only honoured by a stage when its stall is low.
- redirect_valid_out  out  1  fetch loads redirect_pc_out as next PC this cycle.
- redirect_pc_out  out  32  redirect target.
- stall_count_out  out  32  cycles with any stall asserted.
- redirect_count_out  out  32  redirects issued.

## Operation
- FSM states: INIT, RUN, REDIRECT_PENDING.
  - Reset enters INIT with the cycle counter at 0.
  - INIT → RUN after RESET_FLUSH_CYCLES cycles.
  - RUN → REDIRECT_PENDING when a taken branch arrives while instr_read_in && !instr_ready_in.
  - REDIRECT_PENDING → RUN on the cycle instr_ready_in is high.
- INIT: all flushes 1, all stalls 0, redirect_valid 0, counters held at 0.
- Priority in RUN and REDIRECT_PENDING (first match wins):
  1. Data wait: data_access_in && !data_ready_in → fetch, decode, execute and mem stalls all 1, no flush, no redirect. A concurrent mem_branch_taken_in is ignored; the frozen memory stage re-presents it.
  2. Taken branch in RUN:
     - Bus idle or completing: redirect_valid 1 with redirect_pc = mem_branch_pc_in (combinational); fetch, decode and execute flushes 1.
     - Bus outstanding: latch mem_branch_pc_in, go to REDIRECT_PENDING. Flush decode and execute, fetch_stall 1.
  3. REDIRECT_PENDING:
     - While !instr_ready_in: fetch_stall 1, decode_flush 1.
     - On the ready cycle: fetch_flush 1 (discard the wrong-path word), redirect_valid 1 with the latched PC.
  4. Load-use: execute_mem_read_en_in && execute_rd_in != 0 && (rs1 match with rs1_read, or rs2 match with rs2_read) → fetch and decode stalls 1, execute_flush 1.
  5. Instruction wait: instr_read_in && !instr_ready_in → fetch_stall 1, decode_flush 1.
  6. Otherwise all outputs 0.
- A taken branch arriving in REDIRECT_PENDING is impossible: the branch's own younger instructions are bubbles. If it does arrive, the newest target overwrites the latch.
- mem_flush_out is 1 only in INIT.
- Counters:
  - stall_count increments in any non-INIT cycle with any stall high.
  - redirect_count increments on every cycle with redirect_valid 1.
  - Both wrap at 2^32 to 0.

## Timing
- Stall, flush and redirect outputs are combinational from inputs and state, valid in the same cycle.
- State, the latched PC and the counters update on the rising edge.
- Reset values: state INIT, latched PC 0, both counters 0. While reset_n is low, outputs are those of INIT: flushes 1, stalls 0, redirect 0.
- Reset asserted mid-REDIRECT_PENDING drops the pending redirect.
- A load-use hazard costs exactly one bubble.
- A taken branch costs three flushed instructions.
- A pending redirect is delivered in the same cycle as instr_ready_in.

## Structure
- Shared package rv32_hazard_pkg: FSM state enum (INIT, RUN, REDIRECT_PENDING) and the reset-flush counter width, $clog2(RESET_FLUSH_CYCLES+1).
- One sub-module, rv32_perf_counter: a 32-bit enable counter with async active-low reset, instantiated twice.

## Test plan
- Reset: release reset_n with RESET_FLUSH_CYCLES=4 → all flushes 1 for exactly 4 cycles, then all outputs 0, counters 0.
- Load-use: execute load with rd=5, decode rs2=5 and rs2_read=1 → one cycle of fetch/decode stall plus execute_flush, stall_count=1. Repeat with rd=0 → no stall.
- Branch, bus idle: taken branch with target 0x0000_0100 → redirect_valid 1 with pc 0x100, fetch/decode/execute flush 1, redirect_count=1.
- Branch during instruction wait:
  - Setup: instr_ready low for 3 cycles, taken branch to 0x200 in the first.
  - Required: REDIRECT_PENDING for 3 cycles.
  - Required, ready cycle: fetch_flush 1 and redirect to 0x200.
- Data wait with branch: data_ready low for 2 cycles with mem_branch_taken_in high → all four stalls 1, no redirect, stall_count +2.
- Counter wrap: force stall_count to 0xFFFF_FFFF, apply one stall cycle → 0.
